// File: rtl/rgb_pwm_fader.sv
// Three-channel PWM generator with a linear colour-fade sequencer for the SB_RGBA_DRV PWM inputs.
// Optional macro RGB_PWM_FADER_GAMMA_EN squares the compare value for perceptual brightness.
module rgb_pwm_fader #(
    parameter int PWM_BITS  = 8,
    parameter int PRESCALE  = 64,
    parameter int FADE_STEP = 4
) (
    input  logic                    int_osc,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    target_valid,
    output logic                    target_ready,
    input  logic [3*PWM_BITS-1:0]   target_rgb,
    output logic                    pwm_red,
    output logic                    pwm_green,
    output logic                    pwm_blue,
    output logic                    fade_done
);

    localparam int PRESC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DIV_W   = (FADE_STEP > 1) ? $clog2(FADE_STEP) : 1;
    localparam logic [PRESC_W-1:0]  PRESC_MAX = PRESC_W'(PRESCALE - 1);
    localparam logic [DIV_W-1:0]    DIV_MAX   = DIV_W'(FADE_STEP - 1);
    localparam logic [PWM_BITS-1:0] CNT_MAX   = {PWM_BITS{1'b1}};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FADE = 1'b1
    } state_t;

    state_t                       state_r, state_next_s;
    logic [PRESC_W-1:0]           presc_r;
    logic [PWM_BITS-1:0]          pwm_cnt_r;
    logic [DIV_W-1:0]             fade_div_r;
    logic [2:0][PWM_BITS-1:0]     cur_r, act_r, tgt_r, stepped_s, cmp_s;
    logic                         tick_s, wrap_s, transfer_s;
    logic                         load_tgt_s, clear_div_s, div_inc_s, step_en_s, done_set_s;

    // Move one LSB toward the target; equal channels stay put, so no wrap-around.
    function automatic logic [PWM_BITS-1:0] step_toward(input logic [PWM_BITS-1:0] cur,
                                                        input logic [PWM_BITS-1:0] tgt);
        if (cur < tgt) begin
            return cur + PWM_BITS'(1);
        end else if (cur > tgt) begin
            return cur - PWM_BITS'(1);
        end else begin
            return cur;
        end
    endfunction

    function automatic logic [PWM_BITS-1:0] compare_value(input logic [PWM_BITS-1:0] duty);
`ifdef RGB_PWM_FADER_GAMMA_EN
        logic [2*PWM_BITS-1:0] sq;
        sq = {{PWM_BITS{1'b0}}, duty} * {{PWM_BITS{1'b0}}, duty};
        return sq[2*PWM_BITS-1:PWM_BITS];
`else
        return duty;
`endif
    endfunction

    assign tick_s     = (presc_r == PRESC_MAX);
    assign wrap_s     = tick_s && (pwm_cnt_r == CNT_MAX);
    assign transfer_s = target_valid && target_ready;

    // Per-channel next fade value and PWM compare threshold.
    always_comb begin
        stepped_s = '0;
        cmp_s     = '0;
        for (int i = 0; i < 3; i++) begin
            stepped_s[i] = step_toward(cur_r[i], tgt_r[i]);
            cmp_s[i]     = compare_value(act_r[i]);
        end
    end

    // Sequencer next-state and control decode.
    always_comb begin
        state_next_s = state_r;
        load_tgt_s   = 1'b0;
        clear_div_s  = 1'b0;
        div_inc_s    = 1'b0;
        step_en_s    = 1'b0;
        done_set_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (transfer_s) begin
                    load_tgt_s = 1'b1;
                    if (target_rgb == cur_r) begin
                        done_set_s = 1'b1;
                    end else begin
                        state_next_s = FADE;
                        clear_div_s  = 1'b1;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            FADE: begin
                if (enable && wrap_s) begin
                    if (fade_div_r == DIV_MAX) begin
                        step_en_s   = 1'b1;
                        clear_div_s = 1'b1;
                        if (stepped_s == tgt_r) begin
                            state_next_s = IDLE;
                            done_set_s   = 1'b1;
                        end else begin
                            state_next_s = FADE;
                        end
                    end else begin
                        div_inc_s = 1'b1;
                    end
                end else begin
                    state_next_s = FADE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Free-running prescaler and PWM period counter.
    always_ff @(posedge int_osc or posedge rst) begin
        if (rst) begin
            presc_r   <= '0;
            pwm_cnt_r <= '0;
        end else if (tick_s) begin
            presc_r   <= '0;
            pwm_cnt_r <= pwm_cnt_r + PWM_BITS'(1);
        end else begin
            presc_r   <= presc_r + PRESC_W'(1);
        end
    end

    // State register and the ready flag it implies.
    always_ff @(posedge int_osc or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            target_ready <= 1'b1;
        end else begin
            state_r      <= state_next_s;
            target_ready <= (state_next_s == IDLE);
        end
    end

    // Target latch, fade divider, current duties and completion pulse.
    always_ff @(posedge int_osc or posedge rst) begin
        if (rst) begin
            tgt_r      <= '0;
            cur_r      <= '0;
            fade_div_r <= '0;
            fade_done  <= 1'b0;
        end else begin
            fade_done <= done_set_s;
            if (load_tgt_s) begin
                tgt_r <= target_rgb;
            end
            if (step_en_s) begin
                cur_r <= stepped_s;
            end
            if (clear_div_s) begin
                fade_div_r <= '0;
            end else if (div_inc_s) begin
                fade_div_r <= fade_div_r + DIV_W'(1);
            end
        end
    end

    // Active duties change only at the period wrap so a period never sees two thresholds.
    always_ff @(posedge int_osc or posedge rst) begin
        if (rst) begin
            act_r     <= '0;
            pwm_red   <= 1'b0;
            pwm_green <= 1'b0;
            pwm_blue  <= 1'b0;
        end else begin
            if (wrap_s) begin
                act_r <= cur_r;
            end
            pwm_red   <= enable & (pwm_cnt_r < cmp_s[2]);
            pwm_green <= enable & (pwm_cnt_r < cmp_s[1]);
            pwm_blue  <= enable & (pwm_cnt_r < cmp_s[0]);
        end
    end

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// Directed bench for rgb_pwm_fader with PRESCALE = 1 and FADE_STEP = 1 (256-cycle PWM period).
module tb_rgb_pwm_fader;

    logic        int_osc = 1'b0;
    logic        rst;
    logic        enable;
    logic        target_valid;
    logic [23:0] target_rgb;
    logic        target_ready;
    logic        pwm_red, pwm_green, pwm_blue;
    logic        fade_done;

    int checks = 0;
    int errors = 0;
    int r, g, b, d, n;
    int r2, g2, b2, d2;

    rgb_pwm_fader #(
        .PWM_BITS (8),
        .PRESCALE (1),
        .FADE_STEP(1)
    ) dut (
        .int_osc     (int_osc),
        .rst         (rst),
        .enable      (enable),
        .target_valid(target_valid),
        .target_ready(target_ready),
        .target_rgb  (target_rgb),
        .pwm_red     (pwm_red),
        .pwm_green   (pwm_green),
        .pwm_blue    (pwm_blue),
        .fade_done   (fade_done)
    );

    always #5 int_osc = ~int_osc;

    // High cycles per 256-cycle period for a given steady duty.
    function automatic int exp_hi(input int duty);
`ifdef RGB_PWM_FADER_GAMMA_EN
        return (duty * duty) >> 8;
`else
        return duty;
`endif
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic measure(input int cycles, output int hr, output int hg, output int hb,
                           output int hd);
        hr = 0; hg = 0; hb = 0; hd = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge int_osc);
            hr += int'(pwm_red);
            hg += int'(pwm_green);
            hb += int'(pwm_blue);
            hd += int'(fade_done);
        end
    endtask

    task automatic wait_done(input int limit, output int cnt);
        cnt = 0;
        while (fade_done !== 1'b1 && cnt < limit) begin
            @(negedge int_osc);
            cnt++;
        end
    endtask

    // Offer a target for one cycle; returns at the negedge after the transfer edge.
    task automatic send(input logic [23:0] rgb);
        @(negedge int_osc);
        target_rgb   = rgb;
        target_valid = 1'b1;
        check("ready_before_send", int'(target_ready), 1);
        @(negedge int_osc);
        target_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; target_valid = 1'b0; target_rgb = 24'h000000;
        repeat (3) @(negedge int_osc);
        check("reset_pwm_red", int'(pwm_red), 0);
        check("reset_pwm_green", int'(pwm_green), 0);
        check("reset_pwm_blue", int'(pwm_blue), 0);
        check("reset_ready", int'(target_ready), 1);
        check("reset_done", int'(fade_done), 0);
        rst = 1'b0; enable = 1'b1;

        // Idle with no target: nothing lights up.
        measure(1024, r, g, b, d);
        check("idle_hi_sum", r + g + b, 0);
        check("idle_done_pulses", d, 0);
        check("idle_ready", int'(target_ready), 1);

        // Long fade from black to {0x80,0x00,0xFF}: 255 steps.
        send(24'h8000FF);
        check("fade1_ready_drop", int'(target_ready), 0);
        wait_done(66000, n);
        check("fade1_done_seen", int'(fade_done), 1);
        check("fade1_duration", int'(n >= 65025 && n <= 65280), 1);
        @(negedge int_osc);
        check("fade1_done_one_cycle", int'(fade_done), 0);
        check("fade1_ready_back", int'(target_ready), 1);
        measure(300, r, g, b, d);
        check("fade1_no_extra_done", d, 0);
        measure(256, r, g, b, d);
        check("fade1_red_hi", r, exp_hi(128));
        check("fade1_green_hi", g, exp_hi(0));
        check("fade1_blue_hi", b, exp_hi(255));

        // Opposite-direction steps on red and green in the same step.
        send(24'h7E02FF);
        check("fade2_ready_drop", int'(target_ready), 0);
        wait_done(600, n);
        check("fade2_done_seen", int'(fade_done), 1);
        check("fade2_duration", int'(n >= 257 && n <= 512), 1);
        @(negedge int_osc);
        check("fade2_done_one_cycle", int'(fade_done), 0);
        measure(300, r, g, b, d);
        measure(256, r, g, b, d);
        check("fade2_red_hi", r, exp_hi(126));
        check("fade2_green_hi", g, exp_hi(2));
        check("fade2_blue_hi", b, exp_hi(255));

        // Target equal to current: immediate done, no FADE.
        send(24'h7E02FF);
        check("same_done_pulse", int'(fade_done), 1);
        check("same_ready_kept", int'(target_ready), 1);
        @(negedge int_osc);
        check("same_done_one_cycle", int'(fade_done), 0);

        // Pause mid-fade; an offered target during the pause is ignored.
        send(24'h7E06FF);
        check("pause_ready_drop", int'(target_ready), 0);
        measure(300, r, g, b, d);
        check("pause_pre_no_done", d, 0);
        enable = 1'b0;
        measure(100, r, g, b, d);
        target_rgb = 24'h000000; target_valid = 1'b1;
        @(negedge int_osc);
        target_valid = 1'b0;
        measure(667, r2, g2, b2, d2);
        check("pause_outputs_low", r + g + b + r2 + g2 + b2, 0);
        check("pause_no_done", d + d2, 0);
        check("pause_ready_low", int'(target_ready), 0);
        enable = 1'b1;
        wait_done(1100, n);
        check("resume_done_seen", int'(fade_done), 1);
        check("resume_duration", int'(n >= 257 && n <= 1024), 1);
        @(negedge int_osc);
        measure(300, r, g, b, d);
        measure(256, r, g, b, d);
        check("resume_red_hi", r, exp_hi(126));
        check("resume_green_hi", g, exp_hi(6));
        check("resume_blue_hi", b, exp_hi(255));

        // Reset in the middle of a fade and a period.
        send(24'hFFFF00);
        measure(300, r, g, b, d);
        #2 rst = 1'b1;
        #1;
        check("rst_pwm_sum", int'(pwm_red) + int'(pwm_green) + int'(pwm_blue), 0);
        check("rst_ready", int'(target_ready), 1);
        check("rst_done", int'(fade_done), 0);
        @(negedge int_osc);
        rst = 1'b0;
        measure(600, r, g, b, d);
        check("post_rst_hi_sum", r + g + b, 0);
        check("post_rst_no_done", d, 0);
        check("post_rst_ready", int'(target_ready), 1);

        // Low duties around the gamma threshold.
        send(24'h0F1000);
        wait_done(5000, n);
        check("low_done_seen", int'(fade_done), 1);
        @(negedge int_osc);
        measure(300, r, g, b, d);
        measure(256, r, g, b, d);
        check("low_red_hi", r, exp_hi(15));
        check("low_green_hi", g, exp_hi(16));
        check("low_blue_hi", b, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
